// File: rtl/ts_slot_mux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ts_slot_mux_pkg                                                    |
// | Shared frame-FSM state type, marker defaults and width helper.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ts_slot_mux_pkg;

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_HDR  = 2'd1,
    S_PASS = 2'd2,
    S_INS  = 2'd3
  } state_t;

  localparam logic [7:0] HEAD_VAL_DEF = 8'hFF;
  localparam logic [7:0] FREE_VAL_DEF = 8'hEE;
  localparam logic [7:0] TAG_BASE_DEF = 8'hE0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ts_slot_mux_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ts_slot_mux_if                                                     |
// | TS stream, channel write and status signals of the slot mux.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface ts_slot_mux_if #(
  parameter int W      = 8,
  parameter int NUM_CH = 4
);
  logic                  sync;
  logic [W-1:0]          ts_in;
  logic [NUM_CH*W-1:0]   din;
  logic [NUM_CH-1:0]     wr_en;
  logic [NUM_CH-1:0]     full;
  logic [W-1:0]          ts_out;
  logic                  ts_sop;
  logic                  ins;
  logic [2:0]            ins_ch;
  logic                  frm_err;
  logic [NUM_CH-1:0]     ovf;

  modport master (
    output sync, ts_in, din, wr_en,
    input  full, ts_out, ts_sop, ins, ins_ch, frm_err, ovf
  );

  modport slave (
    input  sync, ts_in, din, wr_en,
    output full, ts_out, ts_sop, ins, ins_ch, frm_err, ovf
  );
endinterface
`default_nettype wire

// File: rtl/ts_slot_mux_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ts_slot_mux_fifo                                                   |
// | Single-clock first-word-fall-through FIFO with count and overflow. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ts_slot_mux_fifo #(
  parameter int W  = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr,
  input  logic [W-1:0]  i_din,
  input  logic          i_rd,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic [AW:0]   o_count,
  output logic          o_ovf
);
  localparam int          c_DEPTH    = 1 << AW;
  localparam logic [AW:0] c_FULL_CNT = (AW+1)'(c_DEPTH);

  logic [W-1:0]  r_mem [c_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          w_full;
  logic          w_do_wr;
  logic          w_do_rd;

  // Full is judged on the pre-edge count, so a write to a full FIFO drops even if a pop coincides.
  assign w_full  = (r_count == c_FULL_CNT);
  assign w_do_wr = i_wr & ~w_full;
  assign w_do_rd = i_rd & (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_do_wr) r_wp <= r_wp + AW'(1);
      if (w_do_rd) r_rp <= r_rp + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_ovf <= i_wr & w_full;
    end
  end

  assign o_dout  = r_mem[r_rp];
  assign o_full  = w_full;
  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: rtl/ts_slot_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ts_slot_mux                                                        |
// | Fills free TS frames with whole packets from round-robin channels. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ts_slot_mux
  import ts_slot_mux_pkg::*;
#(
  parameter int           W        = 8,
  parameter int           NUM_CH   = 4,
  parameter int           FIFO_AW  = 5,
  parameter int           MARK_POS = 2,
  parameter int           PAY_LEN  = 9,
  parameter logic [W-1:0] HEAD_VAL = HEAD_VAL_DEF,
  parameter logic [W-1:0] FREE_VAL = FREE_VAL_DEF,
  parameter logic [W-1:0] TAG_BASE = TAG_BASE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  ts_slot_mux_if.slave bus
);
  localparam int                 c_FL    = MARK_POS + 1 + PAY_LEN;
  localparam int                 c_CNT_W = clog2(c_FL + 1);
  localparam logic [c_CNT_W-1:0] c_MARK  = c_CNT_W'(MARK_POS);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_FL - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  state_t                      r_state;
  state_t                      w_state_nx;
  logic [c_CNT_W-1:0]          r_cnt;
  logic [c_CNT_W-1:0]          w_cnt_nx;
  logic [2:0]                  r_ptr;
  logic [2:0]                  w_ptr_nx;
  logic [2:0]                  r_ch;
  logic [2:0]                  w_ch_nx;

  logic [W-1:0]                r_ts_out;
  logic                        r_sop;
  logic                        r_ins;
  logic [2:0]                  r_ins_ch;
  logic                        r_err;

  logic [W-1:0]                w_out;
  logic                        w_sop;
  logic                        w_ins;
  logic                        w_err;
  logic [W-1:0]                w_pay;

  logic [NUM_CH-1:0][W-1:0]    w_head;
  logic [NUM_CH-1:0][FIFO_AW:0] w_count;
  logic [NUM_CH-1:0]           w_elig;
  logic [NUM_CH-1:0]           w_pop;
  logic [7:0]                  w_elig8;
  logic [3:0]                  w_idx;
  logic                        w_grant_ok;
  logic [2:0]                  w_grant_ch;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ts_slot_mux_fifo #(
      .W  (W),
      .AW (FIFO_AW)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (bus.wr_en[c]),
      .i_din   (bus.din[c*W +: W]),
      .i_rd    (w_pop[c]),
      .o_dout  (w_head[c]),
      .o_full  (bus.full[c]),
      .o_count (w_count[c]),
      .o_ovf   (bus.ovf[c])
    );
    assign w_elig[c] = (int'(w_count[c]) >= PAY_LEN);
    assign w_pop[c]  = (r_state == S_INS) && (r_ch == 3'(c));
  end

  assign w_elig8 = 8'(w_elig);

  // Scanning from the far end leaves the first eligible channel after r_ptr as the winner.
  always_comb begin
    w_grant_ok = 1'b0;
    w_grant_ch = r_ptr;
    w_idx      = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_ptr} + 4'(i);
      if (w_idx >= 4'(NUM_CH)) w_idx = w_idx - 4'(NUM_CH);
      if (w_elig8[w_idx[2:0]]) begin
        w_grant_ok = 1'b1;
        w_grant_ch = w_idx[2:0];
      end
    end
  end

  always_comb begin
    w_pay = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_pop[c]) w_pay = w_head[c];
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_ptr_nx   = r_ptr;
    w_ch_nx    = r_ch;
    w_out      = bus.ts_in;
    w_sop      = 1'b0;
    w_ins      = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (bus.sync) begin
          if (bus.ts_in == HEAD_VAL) begin
            w_state_nx = S_HDR;
            w_cnt_nx   = c_ONE;
            w_sop      = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_HDR: begin
        w_err    = bus.sync;
        w_cnt_nx = r_cnt + c_ONE;
        if (r_cnt == c_MARK) begin
          if ((bus.ts_in == FREE_VAL) && w_grant_ok) begin
            w_out      = TAG_BASE + W'(w_grant_ch);
            w_ins      = 1'b1;
            w_ch_nx    = w_grant_ch;
            w_ptr_nx   = (w_grant_ch == 3'(NUM_CH - 1)) ? 3'd0 : w_grant_ch + 3'd1;
            w_state_nx = S_INS;
          end else begin
            w_state_nx = S_PASS;
          end
        end
      end
      S_PASS, S_INS: begin
        w_err = bus.sync;
        if (r_state == S_INS) w_out = w_pay;
        if (r_cnt == c_LAST) begin
          w_state_nx = S_HUNT;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + c_ONE;
        end
      end
      default: begin
        w_state_nx = S_HUNT;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_HUNT;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_ptr   <= w_ptr_nx;
      r_ch    <= w_ch_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts_out <= '0;
      r_sop    <= 1'b0;
      r_ins    <= 1'b0;
      r_ins_ch <= '0;
      r_err    <= 1'b0;
    end else begin
      r_ts_out <= w_out;
      r_sop    <= w_sop;
      r_ins    <= w_ins;
      r_err    <= w_err;
      if (w_ins) r_ins_ch <= w_ch_nx;
    end
  end

  assign bus.ts_out  = r_ts_out;
  assign bus.ts_sop  = r_sop;
  assign bus.ins     = r_ins;
  assign bus.ins_ch  = r_ins_ch;
  assign bus.frm_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ts_slot_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ts_slot_mux                                                     |
// | Scoreboard bench: queue-based frame model vs. ts_slot_mux.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ts_slot_mux;
  localparam int         W        = 8;
  localparam int         NUM_CH   = 4;
  localparam int         FIFO_AW  = 5;
  localparam int         MARK_POS = 2;
  localparam int         PAY_LEN  = 9;
  localparam int         FL       = MARK_POS + 1 + PAY_LEN;
  localparam int         DEPTH    = 1 << FIFO_AW;
  localparam logic [7:0] HV       = 8'hFF;
  localparam logic [7:0] FV       = 8'hEE;
  localparam logic [7:0] TAG      = 8'hE0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ts_slot_mux_if #(.W(W), .NUM_CH(NUM_CH)) bus ();

  ts_slot_mux #(
    .W        (W),
    .NUM_CH   (NUM_CH),
    .FIFO_AW  (FIFO_AW),
    .MARK_POS (MARK_POS),
    .PAY_LEN  (PAY_LEN),
    .HEAD_VAL (HV),
    .FREE_VAL (FV),
    .TAG_BASE (TAG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]        out;
    logic              sop;
    logic              ins;
    logic [2:0]        ch;
    logic              err;
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] full;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rnd_wr = 1'b0;

  // Reference model: frame position (-1 = hunting), chosen channel, pointer, channel FIFOs.
  logic [7:0] mq [NUM_CH][$];
  int         m_pos;
  int         m_cur;
  int         m_rr;
  logic [2:0] m_ch;

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    m_pos = -1;
    m_cur = -1;
    m_rr  = 0;
    m_ch  = 3'd0;
  endfunction

  function automatic void model_step(input bit s, input logic [7:0] t,
                                     input logic [NUM_CH-1:0] we, input logic [NUM_CH*W-1:0] d);
    exp_t e;
    int   sz0 [NUM_CH];
    int   c;
    for (int k = 0; k < NUM_CH; k++) sz0[k] = mq[k].size();
    e     = '0;
    e.out = t;
    if (m_pos < 0) begin
      if (s) begin
        if (t == HV) begin
          e.sop = 1'b1;
          m_pos = 1;
          m_cur = -1;
        end else begin
          e.err = 1'b1;
        end
      end
    end else begin
      e.err = s;
      if (m_pos == MARK_POS) begin
        if (t == FV) begin
          for (int k = 0; k < NUM_CH; k++) begin
            c = (m_rr + k) % NUM_CH;
            if (m_cur < 0 && sz0[c] >= PAY_LEN) m_cur = c;
          end
        end
        if (m_cur >= 0) begin
          e.out = TAG + 8'(m_cur);
          e.ins = 1'b1;
          m_ch  = 3'(m_cur);
          m_rr  = (m_cur + 1) % NUM_CH;
        end
      end else if (m_pos > MARK_POS && m_cur >= 0) begin
        e.out = mq[m_cur].pop_front();
      end
      m_pos = (m_pos == FL - 1) ? -1 : m_pos + 1;
    end
    e.ch = m_ch;
    for (int k = 0; k < NUM_CH; k++) begin
      if (we[k]) begin
        if (sz0[k] == DEPTH) e.ovf[k] = 1'b1;
        else mq[k].push_back(d[k*W +: W]);
      end
    end
    for (int k = 0; k < NUM_CH; k++) e.full[k] = (mq[k].size() == DEPTH);
    sb.push_back(e);
  endfunction

  function automatic exp_t cur_act();
    exp_t a;
    a.out  = bus.ts_out;
    a.sop  = bus.ts_sop;
    a.ins  = bus.ins;
    a.ch   = bus.ins_ch;
    a.err  = bus.frm_err;
    a.ovf  = bus.ovf;
    a.full = bus.full;
    return a;
  endfunction

  function automatic void check(input string name, input exp_t a, input exp_t e);
    n_cmp = n_cmp + 1;
    if (a !== e) begin
      n_err = n_err + 1;
      $display("FAIL %s @%0t: got out=%h sop=%b ins=%b ch=%0d err=%b ovf=%b full=%b, expected out=%h sop=%b ins=%b ch=%0d err=%b ovf=%b full=%b",
               name, $time, a.out, a.sop, a.ins, a.ch, a.err, a.ovf, a.full,
               e.out, e.sop, e.ins, e.ch, e.err, e.ovf, e.full);
    end
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (sb.size() > 0) check("stream", cur_act(), sb.pop_front());
    end
  end

  task automatic step(input bit s, input logic [7:0] t,
                      input logic [NUM_CH-1:0] we, input logic [NUM_CH*W-1:0] d);
    bus.sync  = s;
    bus.ts_in = t;
    bus.wr_en = we;
    bus.din   = d;
    model_step(s, t, we, d);
    @(posedge clk);
    #1;
  endtask

  task automatic tstep(input bit s, input logic [7:0] t);
    logic [NUM_CH-1:0]   we;
    logic [NUM_CH*W-1:0] d;
    we = '0;
    d  = '0;
    if (rnd_wr) begin
      for (int c = 0; c < NUM_CH; c++) we[c] = ($urandom_range(0, 99) < 30);
      d = $urandom;
    end
    step(s, t, we, d);
  endtask

  task automatic frame(input logic [7:0] mark, input bit with_sync, input int glitch);
    logic [7:0] b;
    for (int i = 0; i < FL; i++) begin
      b = (i == 0) ? HV : (i == MARK_POS) ? mark : 8'($urandom);
      tstep((i == 0) ? with_sync : (i == glitch), b);
    end
  endtask

  task automatic fill(input int ch, input int n, input logic [7:0] base);
    logic [NUM_CH-1:0]   we;
    logic [NUM_CH*W-1:0] d;
    for (int i = 0; i < n; i++) begin
      we            = '0;
      we[ch]        = 1'b1;
      d             = '0;
      d[ch*W +: W]  = base + 8'(i);
      step(1'b0, 8'($urandom), we, d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst       = 1'b1;
    bus.sync  = 1'b0;
    bus.wr_en = '0;
    #1;
    check("async_reset", cur_act(), '0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : stim
    bus.sync  = 1'b0;
    bus.ts_in = '0;
    bus.wr_en = '0;
    bus.din   = '0;
    model_reset();
    #1 rst = 1'b1;
    #2;
    check("reset_state", cur_act(), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    // Empty FIFOs: free frame passes untouched.
    frame(FV, 1'b1, -1);
    // Single packet in ch1.
    fill(1, 9, 8'h10);
    frame(FV, 1'b1, -1);
    // Round robin over ch0/ch2, then passthrough, then refilled ch0.
    do_reset();
    fill(0, 9, 8'h20);
    fill(2, 9, 8'h40);
    repeat (3) frame(FV, 1'b1, -1);
    fill(0, 9, 8'h60);
    frame(FV, 1'b1, -1);
    // Framing errors: bad header, SYNC inside a frame, back-to-back frames.
    tstep(1'b1, 8'h3C);
    tstep(1'b0, 8'h00);
    frame(FV, 1'b1, 5);
    frame(8'h12, 1'b1, -1);
    frame(FV, 1'b0, -1);
    // Overflow on ch3.
    fill(3, 33, 8'h80);
    tstep(1'b0, 8'h55);
    tstep(1'b0, 8'hAA);
    // Reset in the middle of an insert.
    do_reset();
    fill(0, 9, 8'hA0);
    for (int i = 0; i <= MARK_POS + 4; i++)
      tstep(i == 0, (i == 0) ? HV : (i == MARK_POS) ? FV : 8'($urandom));
    do_reset();
    frame(FV, 1'b1, -1);

    // Randomised traffic with concurrent channel writes.
    rnd_wr = 1'b1;
    repeat (60) begin
      repeat ($urandom_range(0, 2)) tstep($urandom_range(0, 9) == 0, 8'($urandom));
      frame(($urandom_range(0, 9) < 7) ? FV : 8'($urandom),
            $urandom_range(0, 9) != 0,
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, FL - 1)) : -1);
    end
    rnd_wr = 1'b0;
    tstep(1'b0, 8'h00);

    repeat (4) @(negedge clk);
    n_cmp = n_cmp + 1;
    if (sb.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL drain: %0d expected outputs never compared, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
